// File: rtl/hs_ram_arbiter.sv
// Arbitrates the single-port work RAM between the Z80 (default owner) and the hiscore engine.
// The hiscore side is granted only while the CPU is paused, with a guard gap on each handover.
module hs_ram_arbiter #(
    parameter int unsigned      HS_AW    = 16,
    parameter int unsigned      RAM_AW   = 11,
    parameter logic [HS_AW-1:0] RAM_BASE = 16'h6000,
    parameter int unsigned      RD_LAT   = 1,
    parameter int unsigned      GUARD    = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_paused,
    input  logic              cpu_ram_cs,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              hs_access,
    input  logic              hs_write,
    input  logic [HS_AW-1:0]  hs_address,
    input  logic [7:0]        hs_data_in,
    output logic [7:0]        hs_data_out,
    output logic              hs_valid,
    output logic              hs_grant,
    output logic              hs_abort,
    output logic              hs_oob,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout
);

    typedef enum logic [1:0] {StCpu, StToHs, StHs, StToCpu} state_e;

    // Window bounds carry one extra bit so the top of the window cannot wrap.
    localparam logic [HS_AW:0] WIN_LO     = {1'b0, RAM_BASE};
    localparam logic [HS_AW:0] WIN_HI     = WIN_LO + (HS_AW + 1)'(2 ** RAM_AW);
    localparam logic [2:0]     GUARD_LAST = 3'(GUARD - 1);

    state_e            state_q, state_d;
    logic [2:0]        guard_q, guard_d;
    logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [RD_LAT-1:0] pipe_w_q, pipe_w_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              abort_q, abort_d;
    logic              oob_q, oob_d;
    logic              in_window;
    logic              launch;

    assign in_window = ({1'b0, hs_address} >= WIN_LO) && ({1'b0, hs_address} < WIN_HI);

    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        ram_addr = cpu_addr;
        ram_din  = cpu_dout;
        ram_we   = 1'b0;
        hs_grant = 1'b0;
        launch   = 1'b0;
        abort_d  = 1'b0;
        oob_d    = oob_q;

        unique case (state_q)
            StCpu: begin
                ram_we  = cpu_ram_cs & cpu_we;
                guard_d = '0;
                if (hs_access && cpu_paused && !cpu_ram_cs) begin
                    state_d = StToHs;
                end
            end
            StToHs: begin
                if (!cpu_paused) begin
                    state_d = StCpu;
                    guard_d = '0;
                end else if (guard_q == GUARD_LAST) begin
                    state_d = StHs;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q + 3'd1;
                end
            end
            StHs: begin
                hs_grant = 1'b1;
                ram_addr = hs_address[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
                ram_din  = hs_data_in;
                launch   = hs_access & ~hs_write;
                if (hs_access && !in_window) begin
                    oob_d = 1'b1;
                end
                // Losing the pause revokes the grant and kills any write this cycle.
                if (!cpu_paused) begin
                    state_d = StToCpu;
                    abort_d = 1'b1;
                end else begin
                    ram_we = hs_write & in_window;
                    if (!hs_access) begin
                        state_d = StToCpu;
                    end
                end
            end
            StToCpu: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = StCpu;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q + 3'd1;
                end
            end
            default: state_d = StCpu;
        endcase

        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Read pipeline: tracks launch and window-hit; flushed whenever the grant is not held.
    always_comb begin
        pipe_v_d    = '0;
        pipe_w_d    = '0;
        pipe_v_d[0] = launch;
        pipe_w_d[0] = in_window;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_w_d[i] = pipe_w_q[i-1];
        end
        if (state_q != StHs) begin
            pipe_v_d = '0;
        end
        valid_d = (state_q == StHs) && pipe_v_q[RD_LAT-1];
        data_d  = data_q;
        if (valid_d) begin
            data_d = pipe_w_q[RD_LAT-1] ? ram_dout : 8'h00;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= StCpu;
            guard_q  <= '0;
            pipe_v_q <= '0;
            pipe_w_q <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
            oob_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            pipe_v_q <= pipe_v_d;
            pipe_w_q <= pipe_w_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            abort_q  <= abort_d;
            oob_q    <= oob_d;
        end
    end

    assign hs_data_out = data_q;
    assign hs_valid    = valid_q;
    assign hs_abort    = abort_q;
    assign hs_oob      = oob_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Self-checking bench for hs_ram_arbiter: directed handover scenarios plus randomized
// CPU/hiscore sessions compared against a shadow-memory transaction model.
module tb_hs_ram_arbiter;

    localparam int unsigned HS_AW    = 16;
    localparam int unsigned RAM_AW   = 11;
    localparam int          BASE     = 'h6000;
    localparam int          WIN      = 2048;
    localparam int unsigned RD_LAT   = 1;
    localparam int unsigned GUARD    = 2;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              cpu_paused, cpu_ram_cs, cpu_we;
    logic [RAM_AW-1:0] cpu_addr;
    logic [7:0]        cpu_dout;
    logic              hs_access, hs_write;
    logic [HS_AW-1:0]  hs_address;
    logic [7:0]        hs_data_in, hs_data_out;
    logic              hs_valid, hs_grant, hs_abort, hs_oob;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_din, ram_dout;
    logic              ram_we;

    hs_ram_arbiter #(
        .HS_AW    (HS_AW),
        .RAM_AW   (RAM_AW),
        .RAM_BASE (16'h6000),
        .RD_LAT   (RD_LAT),
        .GUARD    (GUARD)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .cpu_paused  (cpu_paused),
        .cpu_ram_cs  (cpu_ram_cs),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .hs_access   (hs_access),
        .hs_write    (hs_write),
        .hs_address  (hs_address),
        .hs_data_in  (hs_data_in),
        .hs_data_out (hs_data_out),
        .hs_valid    (hs_valid),
        .hs_grant    (hs_grant),
        .hs_abort    (hs_abort),
        .hs_oob      (hs_oob),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_dout    (ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // The work RAM itself, with RD_LAT cycles of read latency.
    logic [7:0] ram_mem [WIN];
    logic [7:0] rd_pipe [RD_LAT];
    always @(posedge clk_sys) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        rd_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[RD_LAT-1];

    // Reference model state.
    logic [7:0] smem [WIN];
    int         dueq[$];
    logic [7:0] dataq[$];
    logic       oob_m, oob_next;
    int         abort_cyc;
    int         cyc;
    int         n_checks, n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic settle();
        logic exp_v;
        @(negedge clk_sys);
        exp_v = (dueq.size() > 0) && (dueq[0] == cyc);
        check_eq("hs_valid", hs_valid, exp_v);
        if (exp_v) begin
            check_eq("hs_data_out", hs_data_out, dataq[0]);
            void'(dueq.pop_front());
            void'(dataq.pop_front());
        end
        check_eq("hs_abort", hs_abort, cyc == abort_cyc);
        check_eq("hs_oob", hs_oob, oob_m);
    endtask

    task automatic adv();
        @(posedge clk_sys);
        if (reset) begin
            oob_m = 1'b0;
            dueq.delete();
            dataq.delete();
            abort_cyc = -1;
        end else if (oob_next) begin
            oob_m = 1'b1;
        end
        oob_next = 1'b0;
        #1;
        cyc++;
    endtask

    task automatic cpu_cycle(input logic cs, input logic we, input logic [10:0] a,
                             input logic [7:0] d, input logic paused, input logic acc);
        cpu_ram_cs = cs; cpu_we = we; cpu_addr = a; cpu_dout = d;
        cpu_paused = paused; hs_access = acc; hs_write = 1'b0;
        settle();
        check_eq("cpu ram_we", ram_we, cs & we);
        if (cs) begin
            check_eq("cpu ram_addr", ram_addr, a);
            check_eq("cpu ram_din", ram_din, d);
        end
        check_eq("cpu hs_grant", hs_grant, 1'b0);
        if (cs && we) smem[a] = d;
        adv();
        cpu_ram_cs = 1'b0; cpu_we = 1'b0;
    endtask

    // Request issued with CPU idle: grant expected exactly GUARD+1 cycles later.
    task automatic start_session();
        cpu_ram_cs = 1'b0; cpu_we = 1'b0; cpu_paused = 1'b1;
        hs_access = 1'b1; hs_write = 1'b0; hs_address = 16'h6000;
        for (int i = 0; i <= int'(GUARD); i++) begin
            settle();
            check_eq("handover grant", hs_grant, 1'b0);
            check_eq("handover ram_we", ram_we, 1'b0);
            adv();
        end
    endtask

    task automatic hs_op(input logic w, input logic [15:0] a, input logic [7:0] d);
        int   ia, off;
        logic inwin;
        hs_access = 1'b1; hs_write = w; hs_address = a; hs_data_in = d;
        ia    = int'(a);
        inwin = (ia >= BASE) && (ia < BASE + WIN);
        off   = (ia - BASE) & (WIN - 1);
        settle();
        check_eq("hs grant", hs_grant, 1'b1);
        check_eq("hs ram_we", ram_we, w && inwin);
        if (w && inwin) begin
            check_eq("hs ram_addr", ram_addr, off);
            check_eq("hs ram_din", ram_din, d);
            smem[off] = d;
        end
        if (!w) begin
            dueq.push_back(cyc + int'(RD_LAT) + 1);
            dataq.push_back(inwin ? smem[off] : 8'h00);
        end
        if (!inwin) oob_next = 1'b1;
        adv();
    endtask

    task automatic end_session(input logic abort);
        if (abort) begin
            cpu_paused = 1'b0; hs_access = 1'b1; hs_write = 1'b1;
            hs_address = 16'h6000 + 16'($urandom_range(0, 2047));
            hs_data_in = 8'($urandom);
        end else begin
            hs_access = 1'b0; hs_write = 1'b0;
        end
        settle();
        check_eq("exit grant", hs_grant, 1'b1);
        check_eq("exit ram_we", ram_we, 1'b0);
        if (abort) abort_cyc = cyc + 1;
        // Reads whose data would land after the grant is gone are dropped.
        while (dueq.size() > 0 && dueq[$] > cyc + 1) begin
            void'(dueq.pop_back());
            void'(dataq.pop_back());
        end
        adv();
        hs_access = 1'b0; hs_write = 1'b0;
        for (int i = 0; i < int'(GUARD); i++) begin
            settle();
            check_eq("release grant", hs_grant, 1'b0);
            check_eq("release ram_we", ram_we, 1'b0);
            adv();
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; abort_cyc = -1;
        oob_m = 1'b0; oob_next = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            smem[i] = 8'h00;
            ram_mem[i] = 8'h00;
        end
        reset = 1'b1; cpu_paused = 1'b0; cpu_ram_cs = 1'b1; cpu_we = 1'b1;
        cpu_addr = 11'h123; cpu_dout = 8'h99;
        hs_access = 1'b0; hs_write = 1'b0; hs_address = '0; hs_data_in = '0;

        // Reset state; CPU write strobes must be blocked while reset is high.
        @(posedge clk_sys); #1;
        settle();
        check_eq("reset ram_we", ram_we, 1'b0);
        check_eq("reset grant", hs_grant, 1'b0);
        check_eq("reset data", hs_data_out, 8'h00);
        adv();
        reset = 1'b0; cpu_ram_cs = 1'b0; cpu_we = 1'b0;

        // 1: CPU write passes straight through.
        cpu_cycle(1'b1, 1'b1, 11'h010, 8'hA5, 1'b0, 1'b0);

        // 2: hiscore read of 0x6010 returns the CPU's byte.
        start_session();
        hs_op(1'b0, 16'h6010, 8'h00);
        hs_op(1'b0, 16'h6010, 8'h00);

        // 3: in-window write, out-of-window write, boundaries.
        hs_op(1'b1, 16'h6400, 8'h3C);
        hs_op(1'b1, 16'h5FFF, 8'h11);
        hs_op(1'b0, 16'h6400, 8'h00);
        hs_op(1'b1, 16'h67FF, 8'hE7);
        hs_op(1'b0, 16'h67FF, 8'h00);
        hs_op(1'b0, 16'h6800, 8'h00);
        hs_op(1'b0, 16'h6000, 8'h00);
        end_session(1'b0);
        cpu_cycle(1'b1, 1'b0, 11'h400, 8'h00, 1'b0, 1'b0);

        // 4: CPU access coinciding with the request wins.
        cpu_cycle(1'b1, 1'b1, 11'h020, 8'h5A, 1'b1, 1'b1);
        cpu_cycle(1'b1, 1'b1, 11'h021, 8'h6B, 1'b1, 1'b1);
        start_session();
        hs_op(1'b0, 16'h6020, 8'h00);
        hs_op(1'b0, 16'h6021, 8'h00);

        // 5: pause drops mid-session with a write pending.
        hs_op(1'b0, 16'h6010, 8'h00);
        end_session(1'b1);
        cpu_cycle(1'b1, 1'b1, 11'h030, 8'hC3, 1'b0, 1'b0);

        // Pause drops during the guard toward the hiscore side: no abort.
        cpu_paused = 1'b1; hs_access = 1'b1;
        settle(); check_eq("to_hs grant", hs_grant, 1'b0); adv();
        cpu_paused = 1'b0;
        settle(); check_eq("to_hs cancel grant", hs_grant, 1'b0); adv();
        cpu_cycle(1'b1, 1'b1, 11'h031, 8'h3D, 1'b0, 1'b1);

        // 6: reset with an out-of-window read in flight.
        start_session();
        hs_op(1'b0, 16'h5000, 8'h00);
        reset = 1'b1; hs_write = 1'b1; hs_address = 16'h6040; hs_data_in = 8'h77;
        settle();
        check_eq("reset in hs ram_we", ram_we, 1'b0);
        adv();
        reset = 1'b0; hs_access = 1'b0; hs_write = 1'b0; cpu_paused = 1'b0;
        settle();
        check_eq("post-reset grant", hs_grant, 1'b0);
        adv();
        cpu_cycle(1'b1, 1'b1, 11'h040, 8'h12, 1'b0, 1'b0);
        cpu_cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0);

        // Randomized sessions.
        for (int s = 0; s < 30; s++) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                cpu_cycle(1'($urandom), 1'($urandom), 11'($urandom_range(0, 31)), 8'($urandom),
                          1'b0, 1'($urandom));
            end
            start_session();
            for (int k = 0; k < int'($urandom_range(1, 10)); k++) begin
                int r;
                logic [15:0] a;
                r = int'($urandom_range(0, 7));
                if (r == 0)      a = 16'($urandom_range(0, 'h5FFF));
                else if (r == 1) a = 16'($urandom_range('h6800, 'hFFFF));
                else if (r < 5)  a = 16'(BASE + int'($urandom_range(0, 31)));
                else             a = 16'(BASE + int'($urandom_range(0, WIN - 1)));
                hs_op(1'($urandom_range(0, 2) == 0), a, 8'($urandom));
            end
            end_session(1'($urandom));
        end
        cpu_cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
